// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, Decode redirect and the head-entry handshake.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_en;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_addr, id_valid, id_pc, id_instr,
    input  imem_rdata, redirect_en, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_instr,
    output imem_rdata, redirect_en, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch PC plus a {pc, instr} FIFO feeding Decode; redirects flush and reload the PC.
// Optional macro FETCH_QUEUE_STATS_EN adds stall/redirect counters.
module fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]   stat_stall_cycles,
  output logic [31:0]   stat_redirects
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic               full_c, pop_c, push_c;

  // Next-state: redirect flushes everything; otherwise a full queue may still push when it pops.
  always_comb begin
    full_c   = (count_q == CNT_W'(DEPTH));
    pop_c    = (count_q != '0) & bus.id_ready & ~bus.redirect_en;
    push_c   = ~bus.redirect_en & (~full_c | pop_c);
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_en) begin
      pc_d     = bus.redirect_pc & ~ADDR_W'(3);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = (count_q != '0);
  assign bus.id_pc     = bus.id_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign bus.id_instr  = bus.id_valid ? instr_mem_q[rd_ptr_q] : NOP;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cnt_q, redir_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (full_c && !pop_c && !bus.redirect_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.redirect_en && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_redirects    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table with per-row expectations plus a queue scoreboard of fetched PCs.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  bit   clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_stall_cycles, stat_redirects;
`endif

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_redirects    (stat_redirects)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_5A00;
  endfunction

  assign bus.imem_rdata = imem_f(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: PCs are pushed as they are fetched and must be presented at the head in order.
  logic [31:0] sb[$];
  logic [31:0] m_pc = 32'h0;

  always @(negedge clk) begin
    logic sb_pop;
    logic sb_full;
    chk("sb_imem_addr", bus.imem_addr, m_pc);
    chk("sb_id_valid", 32'(bus.id_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("sb_head_pc", bus.id_pc, sb[0]);
      chk("sb_head_instr", bus.id_instr, imem_f(sb[0]));
    end else begin
      chk("sb_empty_pc", bus.id_pc, 32'h0);
      chk("sb_empty_instr", bus.id_instr, 32'h0000_0013);
    end
    if (!rst_n) begin
      sb.delete();
      m_pc = 32'h0;
    end else if (bus.redirect_en) begin
      sb.delete();
      m_pc = bus.redirect_pc & ~32'h3;
    end else begin
      sb_full = (sb.size() == DEPTH);
      sb_pop  = (sb.size() != 0) && bus.id_ready;
      if (sb_pop) void'(sb.pop_front());
      if (!sb_full || sb_pop) begin
        sb.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  typedef struct packed {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic r, input logic rd, input logic rr, input logic [31:0] rp,
                      input logic v, input logic [31:0] p, input logic [31:0] a);
    vec_t e;
    e.rst_n = r; e.ready = rd; e.redir = rr; e.rpc = rp;
    e.valid = v; e.pc = p; e.addr = a;
    vt.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_ready    = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset release and streaming fetch.
    addv(0,1,0,0, 0,32'h00,32'h00);
    addv(1,1,0,0, 1,32'h00,32'h04);
    addv(1,1,0,0, 1,32'h04,32'h08);
    addv(1,1,0,0, 1,32'h08,32'h0C);
    // Stall until full, then pop+push in one cycle and drain.
    addv(0,1,0,0, 0,32'h00,32'h00);
    addv(1,0,0,0, 1,32'h00,32'h04);
    addv(1,0,0,0, 1,32'h00,32'h08);
    addv(1,0,0,0, 1,32'h00,32'h0C);
    addv(1,0,0,0, 1,32'h00,32'h10);
    addv(1,0,0,0, 1,32'h00,32'h10);
    addv(1,0,0,0, 1,32'h00,32'h10);
    addv(1,1,0,0, 1,32'h04,32'h14);
    addv(1,1,0,0, 1,32'h08,32'h18);
    addv(1,1,0,0, 1,32'h0C,32'h1C);
    addv(1,1,0,0, 1,32'h10,32'h20);
    addv(1,1,0,0, 1,32'h14,32'h24);
    // Redirect with three entries queued and Decode ready.
    addv(0,0,0,0, 0,32'h00,32'h00);
    addv(1,0,0,0, 1,32'h00,32'h04);
    addv(1,0,0,0, 1,32'h00,32'h08);
    addv(1,0,0,0, 1,32'h00,32'h0C);
    addv(1,1,1,32'h100, 0,32'h000,32'h100);
    addv(1,1,0,0,       1,32'h100,32'h104);
    addv(1,1,0,0,       1,32'h104,32'h108);
    // Misaligned target, then reset while full and redirecting.
    addv(1,1,1,32'h203, 0,32'h000,32'h200);
    addv(1,0,0,0,       1,32'h200,32'h204);
    addv(1,0,0,0,       1,32'h200,32'h208);
    addv(1,0,0,0,       1,32'h200,32'h20C);
    addv(1,0,0,0,       1,32'h200,32'h210);
    addv(1,0,0,0,       1,32'h200,32'h210);
    addv(0,1,1,32'h40,  0,32'h000,32'h000);
    addv(1,1,0,0,       1,32'h000,32'h004);
    // Counter sequence: reset, fill, five stall cycles, two redirects.
    addv(0,0,0,0, 0,32'h00,32'h00);
    addv(1,0,0,0, 1,32'h00,32'h04);
    addv(1,0,0,0, 1,32'h00,32'h08);
    addv(1,0,0,0, 1,32'h00,32'h0C);
    addv(1,0,0,0, 1,32'h00,32'h10);
    for (int k = 0; k < 5; k++) addv(1,0,0,0, 1,32'h00,32'h10);
    addv(1,0,1,32'h80, 0,32'h00,32'h80);
    addv(1,0,1,32'h80, 0,32'h00,32'h80);

    foreach (vt[i]) begin
      rst_n           = vt[i].rst_n;
      bus.id_ready    = vt[i].ready;
      bus.redirect_en = vt[i].redir;
      bus.redirect_pc = vt[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.id_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d_pc", i), bus.id_pc, vt[i].pc);
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].addr);
      chk($sformatf("v%0d_instr", i), bus.id_instr,
          vt[i].valid ? imem_f(vt[i].pc) : 32'h0000_0013);
`ifdef FETCH_QUEUE_STATS_EN
      if (i == 31) begin
        chk("stat_stall_after_reset", stat_stall_cycles, 32'd0);
        chk("stat_redir_after_reset", stat_redirects, 32'd0);
      end
`endif
    end

`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_stall_cycles", stat_stall_cycles, 32'd5);
    chk("stat_redirects", stat_redirects, 32'd2);
`endif

    bus.redirect_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the Decode stage.
- Owns the fetch PC and drives the address of the combinational instruction memory.
- Buffers {pc, instr} pairs in a small FIFO so that decode stalls (hazard) do not lose fetched instructions.
- Branch/jump redirects from Decode flush the queue and reload the PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address to instruction memory; equals the PC register.
- imem_rdata  in  INSTR_W  instruction at imem_addr, valid in the same cycle (combinational memory).
- redirect_en  in  1  Decode pcWriteEnable; flush the queue and jump.
- redirect_pc  in  ADDR_W  redirect target (pcWriteData).
- id_ready  in  1  Decode accepts the head entry this cycle; driven as ~hazard.
- id_valid  out  1  queue non-empty.
- id_pc  out  ADDR_W  PC of the head entry.
- id_instr  out  INSTR_W  instruction of the head entry.

Behaviour:
- State: pc register, DEPTH-entry storage, wr_ptr and rd_ptr (log2(DEPTH) bits, wrapping), count (0..DEPTH).
- Reset (reset==0 at a rising edge):
  - pc <= RESET_PC; pointers <= 0; count <= 0.
  - Reset has priority over every other input, including mid-redirect and a full queue.
- Outputs:
  - id_valid = (count != 0).
  - When count==0: id_pc = 0 and id_instr = 32'h0000_0013 (NOP).
  - When count!=0: id_pc and id_instr are the head entry, read combinationally from storage.
- pop = id_valid & id_ready & ~redirect_en.
- push = ~redirect_en & ((count < DEPTH) | pop).
  - A full queue that pops in the same cycle still accepts a push.
- On push: store {pc, imem_rdata} at wr_ptr; wr_ptr++ (wrapping); pc <= pc + 4 (modulo 2^ADDR_W).
- On pop: rd_ptr++ (wrapping).
- count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - push & pop: count unchanged.
- When count==DEPTH and there is no pop: pc holds and imem_addr is stable.
- Redirect (redirect_en==1, reset==1):
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; low two bits are forced to zero.
  - Pointers <= 0; count <= 0.
  - No push and no pop that cycle; the current head is discarded even if id_ready==1.
- Latency:
  - An instruction fetched at edge N is visible on id_* after edge N.
  - After reset release, the first valid entry (RESET_PC) appears one cycle later.
  - After a redirect, the target instruction appears on id_* one cycle after the redirect edge.
- id_ready while id_valid==0 is ignored.
- The queue never overflows or underflows; count stays within 0..DEPTH.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined: adds output ports stat_stall_cycles (32) and stat_redirects (32).
  - stat_stall_cycles increments on each cycle with count==DEPTH & ~pop & ~redirect_en.
  - stat_redirects increments on each cycle with redirect_en==1.
  - Both counters are cleared by reset and saturate at 32'hFFFF_FFFF.
- Not defined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then release with id_ready=1 and imem_rdata = f(addr) -> id_valid rises one cycle after release; id_pc sequence 0x0, 0x4, 0x8…, one per cycle; id_instr matches f(id_pc).
- id_ready=0 held for 6 cycles after reset -> count saturates at 4; imem_addr holds 0x10; id_pc stays 0x0; raising id_ready drains 0x0, 0x4, 0x8, 0xC, 0x10 in order with no gaps or duplicates.
- Queue full (4 entries), id_ready=1 for one cycle -> pop and push in the same cycle; count stays 4; imem_addr advances 0x10→0x14.
- redirect_en=1 with redirect_pc=0x100 while queue holds 3 entries and id_ready=1 -> next cycle id_pc=0x100, count=1, and none of the old entries are ever presented again.
- redirect_pc=0x203 -> imem_addr=0x200 next cycle; reset asserted during a full/stalled queue -> id_valid=0, id_instr=0x00000013, imem_addr=RESET_PC at the next edge.
- With FETCH_QUEUE_STATS_EN: 5 full-stall cycles plus 2 redirects -> stat_stall_cycles=5, stat_redirects=2; both read 0 after reset.
